z_interp_seq: RTL and testbench
===============================

Name: z_interp_seq

Overview:
Multi-cycle, parametrised successor of the combinational barycentric Z interpolator in the rasteriser back end. It accepts one triangle (three vertices with x, y, z) plus a sample point over a valid/ready handshake. It computes doubled shoelace areas and the weighted Z numerator, then divides with an iterative restoring divider. It returns the interpolated depth with optional round-to-nearest, saturation and degenerate-triangle flags, and feeds the z-buffer compare stage.

Parameters:
COORD_W, 12, signed width of every x/y coordinate (two's complement)
Z_W, 8, unsigned width of vertex z and of z_out
ROUND, 0, 0 = truncating quotient; 1 = round-half-up (adds a>>1 to numerator before dividing)
(derived, not overridable) AREA_W = 2*COORD_W+2; NUM_W = Z_W+AREA_W+2

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
p_x, p_y, q_x, q_y, r_x, r_y  in  COORD_W each  vertex coordinates, signed
p_z, q_z, r_z  in  Z_W each  vertex depths, unsigned
pt_x, pt_y  in  COORD_W each  sample point, signed
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
z_out  out  Z_W  interpolated depth
overflow  out  1  quotient exceeded 2^Z_W-1; z_out saturated
degenerate  out  1  triangle doubled area is 0; z_out forced 0

Behaviour:
- Reset (async, reset_n=0): state IDLE; in_ready=0 while reset asserted, 1 from first edge after release; out_valid=0, z_out=0, overflow=0, degenerate=0; all datapath registers cleared. Reset mid-operation aborts silently; no result is emitted.
- Handshake: accept when in_valid && in_ready on an edge (edge k). Inputs are captured into registers on that edge and may change afterwards. in_ready=1 only in IDLE. The result is held stable while out_valid && !out_ready. The transfer completes on the edge with out_valid && out_ready, returning to IDLE; a new request can be accepted on the following edge (no same-edge turnaround).
- States: IDLE -> AREA -> MAC -> DIV -> DONE -> IDLE.
- AREA (edge k+1): latch four doubled areas a, a1, a2, a3, each AREA_W unsigned = |shoelace sum| without /2.
  - a uses (p,q,r); a1 uses (pt,q,r); a2 uses (p,pt,r); a3 uses (p,q,pt).
- MAC (edge k+2): num = p_z*a1 + q_z*a2 + r_z*a3 (+ (a>>1) if ROUND=1), NUM_W bits, no truncation.
  - If a==0: go to DONE with z_out=0, degenerate=1, overflow=0; out_valid is visible after edge k+2.
  - Otherwise: go to DIV with counter=0.
- DIV: restoring divide, one quotient bit per edge, MSB first, exactly NUM_W edges (k+3 .. k+2+NUM_W). The last edge enters DONE; out_valid is visible after edge k+2+NUM_W (38 cycles at defaults).
- Output rule: if quotient > 2^Z_W-1, z_out = all ones and overflow=1 (points outside the triangle). Otherwise z_out = quotient[Z_W-1:0] and overflow=0.
- Flags and z_out are valid only while out_valid=1. They keep their values until the next result loads.
- in_valid while busy is ignored (not queued).

Test Plan:
- Defaults; tri p(0,0,z0) q(10,0,z100) r(0,10,z200), pt(5,5) -> a=100, a2=a3=50, num=15000, z_out=150, flags 0, out_valid 38 cycles after accept.
- Same tri, pt(0,0) then pt(10,0) back-to-back with out_ready=1 -> z_out=0 then 100; second in_ready rise follows first out handshake by one edge.
- Tri p(0,0,0) q(10,0,255) r(0,10,7), pt(3,3): ROUND=0 -> z_out=78; ROUND=1 -> z_out=79. pt(1,1): both -> 26.
- Tri p(0,0,0) q(10,0,200) r(0,10,0), pt(20,0) -> num=40000, quotient 400, z_out=255, overflow=1.
- Collinear p(0,0) q(5,5) r(10,10), any pt -> degenerate=1, z_out=0, out_valid 2 cycles after accept. Hold out_ready=0 for 10 cycles: outputs remain stable.
- Assert reset_n=0 mid-DIV (cycle 20) -> out_valid=0 immediately. After release, in_ready=1 on the first edge; a fresh request produces a correct result.

Source files
------------

// File: rtl/z_interp_seq_if.sv
// z_interp_seq_if: request/result handshake bundle for the Z interpolator
interface z_interp_seq_if #(
  parameter int COORD_W = 12,
  parameter int Z_W     = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [COORD_W-1:0] p_x, p_y, q_x, q_y, r_x, r_y, pt_x, pt_y;
  logic        [Z_W-1:0]     p_z, q_z, r_z;
  logic                      out_valid;
  logic                      out_ready;
  logic        [Z_W-1:0]     z_out;
  logic                      overflow;
  logic                      degenerate;
  modport master (
    output in_valid, p_x, p_y, q_x, q_y, r_x, r_y, pt_x, pt_y, p_z, q_z, r_z, out_ready,
    input  in_ready, out_valid, z_out, overflow, degenerate
  );
  modport slave (
    input  in_valid, p_x, p_y, q_x, q_y, r_x, r_y, pt_x, pt_y, p_z, q_z, r_z, out_ready,
    output in_ready, out_valid, z_out, overflow, degenerate
  );
endinterface

// File: rtl/z_interp_seq.sv
// z_interp_seq: multi-cycle barycentric Z interpolator with restoring divider
module z_interp_seq #(
  parameter int COORD_W = 12,
  parameter int Z_W     = 8,
  parameter int ROUND   = 0
) (
  input logic clk,
  input logic reset_n,
  z_interp_seq_if.slave bus
);
  localparam int AREA_W = 2*COORD_W+2;
  localparam int NUM_W  = Z_W+AREA_W+2;
  localparam int CW     = 2*COORD_W+4;
  localparam int CNT_W  = $clog2(NUM_W);
  typedef enum logic [2:0] {IDLE, AREA, MAC, DIV, DONE} state_t;
  state_t                    state;
  logic signed [COORD_W-1:0] px, py, qx, qy, rx, ry, tx, ty;
  logic        [Z_W-1:0]     pz, qz, rz;
  logic        [AREA_W-1:0]  a, a1, a2, a3, rem, rem_n;
  logic        [NUM_W-1:0]   num, q_n;
  logic        [AREA_W:0]    rsh;
  logic                      qb;
  logic        [CNT_W-1:0]   cnt;
  function automatic logic [AREA_W-1:0] area2(
    input logic signed [COORD_W-1:0] ax, ay, bx, by, cx, cy
  );
    logic signed [CW-1:0] x0, y0, x1, y1, x2, y2, s;
    x0 = ax; y0 = ay; x1 = bx; y1 = by; x2 = cx; y2 = cy;
    s = (x1-x0)*(y2-y0) - (y1-y0)*(x2-x0);
    return AREA_W'(s < 0 ? -s : s);
  endfunction
  // one restoring-divide step: num doubles as dividend shifter and quotient collector
  always_comb begin
    rsh   = {rem, num[NUM_W-1]};
    qb    = rsh >= {1'b0, a};
    rem_n = qb ? AREA_W'(rsh - {1'b0, a}) : rsh[AREA_W-1:0];
    q_n   = {num[NUM_W-2:0], qb};
  end
  // control FSM and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      bus.in_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.z_out <= '0;
      bus.overflow <= 1'b0;
      bus.degenerate <= 1'b0;
      {px, py, qx, qy, rx, ry, tx, ty} <= '0;
      {pz, qz, rz} <= '0;
      {a, a1, a2, a3, rem} <= '0;
      num <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            {px, py, qx, qy, rx, ry} <= {bus.p_x, bus.p_y, bus.q_x, bus.q_y, bus.r_x, bus.r_y};
            {tx, ty} <= {bus.pt_x, bus.pt_y};
            {pz, qz, rz} <= {bus.p_z, bus.q_z, bus.r_z};
            state <= AREA;
          end
        end
        AREA: begin
          a <= area2(px, py, qx, qy, rx, ry);
          a1 <= area2(tx, ty, qx, qy, rx, ry);
          a2 <= area2(px, py, tx, ty, rx, ry);
          a3 <= area2(px, py, qx, qy, tx, ty);
          state <= MAC;
        end
        MAC: begin
          num <= NUM_W'(pz)*NUM_W'(a1) + NUM_W'(qz)*NUM_W'(a2) + NUM_W'(rz)*NUM_W'(a3)
               + (ROUND != 0 ? NUM_W'(a >> 1) : '0);
          rem <= '0;
          cnt <= '0;
          if (a == '0) begin
            bus.z_out <= '0;
            bus.overflow <= 1'b0;
            bus.degenerate <= 1'b1;
            bus.out_valid <= 1'b1;
            state <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          num <= q_n;
          rem <= rem_n;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NUM_W-1)) begin
            bus.z_out <= |q_n[NUM_W-1:Z_W] ? '1 : q_n[Z_W-1:0];
            bus.overflow <= |q_n[NUM_W-1:Z_W];
            bus.degenerate <= 1'b0;
            bus.out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_z_interp_seq.sv
// tb_z_interp_seq: directed checks of z_interp_seq (truncating and rounding instances)
module tb_z_interp_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int lat;
  logic stable;
  z_interp_seq_if #(.COORD_W(12), .Z_W(8)) i0 ();
  z_interp_seq_if #(.COORD_W(12), .Z_W(8)) i1 ();
  z_interp_seq #(.COORD_W(12), .Z_W(8), .ROUND(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(i0));
  z_interp_seq #(.COORD_W(12), .Z_W(8), .ROUND(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(i1));
  assign i1.in_valid = i0.in_valid;
  assign i1.out_ready = i0.out_ready;
  assign i1.p_x = i0.p_x;
  assign i1.p_y = i0.p_y;
  assign i1.q_x = i0.q_x;
  assign i1.q_y = i0.q_y;
  assign i1.r_x = i0.r_x;
  assign i1.r_y = i0.r_y;
  assign i1.pt_x = i0.pt_x;
  assign i1.pt_y = i0.pt_y;
  assign i1.p_z = i0.p_z;
  assign i1.q_z = i0.q_z;
  assign i1.r_z = i0.r_z;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input int px, py, pz, qx, qy, qz, rx, ry, rz, tx, ty);
    int w = 0;
    while (!i0.in_ready && w < 100) begin
      tick;
      w++;
    end
    if (w >= 100) chk("in_ready_timeout", 32'(i0.in_ready), 32'd1);
    i0.p_x = 12'(px); i0.p_y = 12'(py); i0.p_z = 8'(pz);
    i0.q_x = 12'(qx); i0.q_y = 12'(qy); i0.q_z = 8'(qz);
    i0.r_x = 12'(rx); i0.r_y = 12'(ry); i0.r_z = 8'(rz);
    i0.pt_x = 12'(tx); i0.pt_y = 12'(ty);
    i0.in_valid = 1'b1;
    tick;
    i0.in_valid = 1'b0;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!i0.out_valid && n < 100) begin
      tick;
      n++;
    end
  endtask
  initial begin
    i0.in_valid = 1'b0;
    i0.out_ready = 1'b0;
    {i0.p_x, i0.p_y, i0.q_x, i0.q_y, i0.r_x, i0.r_y, i0.pt_x, i0.pt_y} = '0;
    {i0.p_z, i0.q_z, i0.r_z} = '0;
    #12;
    chk("rst_in_ready", 32'(i0.in_ready), 32'd0);
    chk("rst_out_valid", 32'(i0.out_valid), 32'd0);
    chk("rst_z_out", 32'(i0.z_out), 32'd0);
    chk("rst_overflow", 32'(i0.overflow), 32'd0);
    chk("rst_degenerate", 32'(i0.degenerate), 32'd0);
    #10 reset_n = 1'b1;
    chk("rel_in_ready_low", 32'(i0.in_ready), 32'd0);
    tick;
    chk("rel_in_ready_high", 32'(i0.in_ready), 32'd1);
    send(0, 0, 0, 10, 0, 100, 0, 10, 200, 5, 5);
    wait_out(lat);
    chk("mid_latency", 32'(lat), 32'd38);
    chk("mid_z", 32'(i0.z_out), 32'd150);
    chk("mid_overflow", 32'(i0.overflow), 32'd0);
    chk("mid_degenerate", 32'(i0.degenerate), 32'd0);
    chk("mid_busy_in_ready", 32'(i0.in_ready), 32'd0);
    i0.out_ready = 1'b1;
    tick;
    chk("mid_done_out_valid", 32'(i0.out_valid), 32'd0);
    chk("mid_done_in_ready", 32'(i0.in_ready), 32'd1);
    send(0, 0, 0, 10, 0, 100, 0, 10, 200, 0, 0);
    wait_out(lat);
    chk("b2b0_latency", 32'(lat), 32'd38);
    chk("b2b0_z", 32'(i0.z_out), 32'd0);
    chk("b2b0_in_ready", 32'(i0.in_ready), 32'd0);
    tick;
    chk("b2b0_hs_out_valid", 32'(i0.out_valid), 32'd0);
    chk("b2b0_hs_in_ready", 32'(i0.in_ready), 32'd1);
    send(0, 0, 0, 10, 0, 100, 0, 10, 200, 10, 0);
    wait_out(lat);
    chk("b2b1_latency", 32'(lat), 32'd38);
    chk("b2b1_z", 32'(i0.z_out), 32'd100);
    send(0, 0, 0, 10, 0, 255, 0, 10, 7, 3, 3);
    wait_out(lat);
    chk("trunc_33_z", 32'(i0.z_out), 32'd78);
    chk("round_33_z", 32'(i1.z_out), 32'd79);
    chk("round_33_valid", 32'(i1.out_valid), 32'd1);
    send(0, 0, 0, 10, 0, 255, 0, 10, 7, 1, 1);
    wait_out(lat);
    chk("trunc_11_z", 32'(i0.z_out), 32'd26);
    chk("round_11_z", 32'(i1.z_out), 32'd26);
    send(0, 0, 0, 10, 0, 200, 0, 10, 0, 20, 0);
    wait_out(lat);
    chk("ovf_z", 32'(i0.z_out), 32'd255);
    chk("ovf_flag", 32'(i0.overflow), 32'd1);
    chk("ovf_degenerate", 32'(i0.degenerate), 32'd0);
    chk("ovf_round_z", 32'(i1.z_out), 32'd255);
    chk("ovf_round_flag", 32'(i1.overflow), 32'd1);
    tick;
    i0.out_ready = 1'b0;
    send(0, 0, 50, 5, 5, 60, 10, 10, 70, 3, 7);
    wait_out(lat);
    chk("deg_latency", 32'(lat), 32'd2);
    chk("deg_flag", 32'(i0.degenerate), 32'd1);
    chk("deg_z", 32'(i0.z_out), 32'd0);
    chk("deg_overflow", 32'(i0.overflow), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick;
      stable = i0.out_valid && i0.degenerate && !i0.overflow && i0.z_out == 8'd0 && !i0.in_ready;
      chk("deg_hold", 32'(stable), 32'd1);
    end
    i0.out_ready = 1'b1;
    tick;
    chk("deg_release", 32'(i0.out_valid), 32'd0);
    send(0, 0, 0, 10, 0, 100, 0, 10, 200, 5, 5);
    repeat (20) tick;
    chk("abort_pre_out_valid", 32'(i0.out_valid), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(i0.in_ready), 32'd0);
    chk("abort_out_valid", 32'(i0.out_valid), 32'd0);
    #10 reset_n = 1'b1;
    tick;
    chk("abort_rel_in_ready", 32'(i0.in_ready), 32'd1);
    chk("abort_rel_out_valid", 32'(i0.out_valid), 32'd0);
    send(0, 0, 0, 10, 0, 100, 0, 10, 200, 5, 5);
    wait_out(lat);
    chk("fresh_latency", 32'(lat), 32'd38);
    chk("fresh_z", 32'(i0.z_out), 32'd150);
    chk("fresh_overflow", 32'(i0.overflow), 32'd0);
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
